// File: rtl/lifo_frame_reverser.sv
// Frame reverser: pushes an in_last-framed byte stream into an external LIFO and pops it back out reversed.
// Optional LIFO_REV_DROP_EN: bytes past DEPTH are discarded and flagged on ovf instead of splitting the frame.
module lifo_frame_reverser #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       stk_we,
    output logic       stk_re,
    output logic [7:0] stk_din,
    input  logic [7:0] stk_dout,
    input  logic       stk_full,
    input  logic       stk_empty,
    output logic       ovf
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_POP,
        S_LOAD,
        S_SEND
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_out_valid, w_out_valid_nxt;
    logic [7:0]    r_out_data, w_out_data_nxt;
    logic          r_out_last, w_out_last_nxt;
    logic          w_room;
    logic          w_in_ready;
    logic          w_we;
    logic          w_re;
    logic          w_unused;

    // Stack status is informational only; occupancy is tracked by r_cnt.
    assign w_unused = ^{stk_full, stk_empty};
    assign w_room   = (r_cnt < CW'(DEPTH));

`ifdef LIFO_REV_DROP_EN
    logic r_ovf, w_ovf_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
`ifdef LIFO_REV_DROP_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
`ifdef LIFO_REV_DROP_EN
            r_ovf       <= w_ovf_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
`ifdef LIFO_REV_DROP_EN
        w_ovf_nxt       = r_ovf;
`endif
        w_in_ready      = 1'b0;
        w_we            = 1'b0;
        w_re            = 1'b0;

        case (r_state)
            S_FILL: begin
`ifdef LIFO_REV_DROP_EN
                w_in_ready = 1'b1;
`else
                w_in_ready = w_room;
`endif
                if (in_valid && w_in_ready) begin
                    if (w_room) begin
                        w_we      = 1'b1;
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
`ifdef LIFO_REV_DROP_EN
                    else begin
                        w_ovf_nxt = 1'b1;
                    end
                    if (in_last) begin
                        w_state_nxt = S_POP;
                    end
`else
                    // A full stack without in_last closes the frame early; the rest forms the next frame.
                    if (in_last || (r_cnt == CW'(DEPTH - 1))) begin
                        w_state_nxt = S_POP;
                    end
`endif
                end
            end
            S_POP: begin
                w_re        = 1'b1;
                w_cnt_nxt   = r_cnt - CW'(1);
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_out_data_nxt  = stk_dout;
                w_out_last_nxt  = (r_cnt == '0);
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = (r_cnt != '0) ? S_POP : S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign stk_we    = w_we;
    assign stk_re    = w_re;
    assign stk_din   = in_data;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
`ifdef LIFO_REV_DROP_EN
    assign ovf       = r_ovf;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_frame_reverser.sv
// Bench for lifo_frame_reverser: directed frame table, random frames against a queue model, reset mid-drain.
module tb_lifo_frame_reverser;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXB  = 24;

    typedef logic [7:0] bq_t[$];
    typedef logic       lq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_last, out_ready;
    logic [7:0] out_data;
    logic       stk_we, stk_re, stk_full, stk_empty, ovf;
    logic [7:0] stk_din, stk_dout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lifo_frame_reverser #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .stk_we(stk_we), .stk_re(stk_re), .stk_din(stk_din), .stk_dout(stk_dout),
        .stk_full(stk_full), .stk_empty(stk_empty), .ovf(ovf)
    );

    // External stack: read data updates on the edge that ends a pop cycle.
    logic [7:0] mem [DEPTH];
    int         sp = 0;
    always @(posedge clk) begin
        if (rst) begin
            sp       <= 0;
            stk_dout <= 8'h00;
        end else begin
            if (stk_we && sp < DEPTH) begin
                mem[sp] <= stk_din;
                sp      <= sp + 1;
            end
            if (stk_re && sp > 0) begin
                stk_dout <= mem[sp-1];
                sp       <= sp - 1;
            end
        end
    end
    assign stk_full  = (sp == DEPTH);
    assign stk_empty = (sp == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer: drives out_ready, collects handshakes, checks hold stability.
    logic rand_ready = 1'b0;
    bq_t  got_d;
    lq_t  got_l;
    logic hold_p = 1'b0;
    logic [7:0] hold_d;
    logic hold_l;
    int   first_valid_cyc = -1;
    int   reopen_cyc = -1;
    logic prev_in_ready = 1'b0;

    always @(negedge clk) begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (rst) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(hold_d));
                chk("hold_last", 32'(out_last), 32'(hold_l));
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            hold_p = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (in_ready && !prev_in_ready) reopen_cyc = cyc;
        end
        prev_in_ready = in_ready;
    end

    // Stack strobes must never overrun or underrun the attached stack.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (stk_re) chk("pop_while_empty", 32'(stk_empty), 32'd0);
            if (stk_we) chk("push_while_full", 32'(stk_full), 32'd0);
        end
    end

    // Reference: each frame reversed; overlong frames split (or truncated with drop enabled).
    function automatic void model(input bq_t d, input lq_t l, output bq_t ed, output lq_t el);
        bq_t frm;
        int  n;
        ed = {};
        el = {};
        frm = {};
        for (int i = 0; i < d.size(); i++) begin
            frm.push_back(d[i]);
`ifdef LIFO_REV_DROP_EN
            if (l[i]) begin
`else
            if (l[i] || frm.size() == DEPTH) begin
`endif
                n = (frm.size() > DEPTH) ? DEPTH : frm.size();
                for (int j = n - 1; j >= 0; j--) begin
                    ed.push_back(frm[j]);
                    el.push_back(j == 0);
                end
                frm = {};
            end
        end
    endfunction

    logic ovf_model = 1'b0;
    int   last_acc_cyc = 0;

    task automatic drive(input bq_t d, input lq_t l);
        int k = 0;
        int w;
        for (int i = 0; i < d.size(); i++) begin
            @(negedge clk);
            chk("ovf_track", 32'(ovf), 32'(ovf_model));
            in_valid = 1'b1;
            in_data  = d[i];
            in_last  = l[i];
            #1;
            w = 0;
            while (!in_ready) begin
                @(negedge clk);
                #1;
                w++;
                if (w > 1000) begin
                    checks++;
                    errors++;
                    $display("FAIL in_ready_timeout: byte %0d never accepted", i);
                    in_valid = 1'b0;
                    return;
                end
            end
            last_acc_cyc = cyc + 1;
`ifdef LIFO_REV_DROP_EN
            if (k >= DEPTH) ovf_model = 1'b1;
`endif
            k = l[i] ? 0 : k + 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("ovf_track", 32'(ovf), 32'(ovf_model));
    endtask

    task automatic wait_out(input int n, input int budget);
        int w = 0;
        while (got_d.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        if (got_d.size() < n) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: got %0d bytes expected %0d", got_d.size(), n);
        end
    endtask

    task automatic compare(input bq_t ed, input lq_t el);
        chk("out_count", 32'(got_d.size()), 32'(ed.size()));
        for (int i = 0; i < ed.size() && i < got_d.size(); i++) begin
            chk("out_data", 32'(got_d[i]), 32'(ed[i]));
            chk("out_last", 32'(got_l[i]), 32'(el[i]));
        end
    endtask

    typedef struct {
        int         n_in;
        logic [7:0] din  [MAXB];
        logic       lin  [MAXB];
        int         n_out;
        logic [7:0] dout [MAXB];
        logic       lout [MAXB];
        logic       rnd_ready;
        logic       timing;
        logic       ovf_after;
    } vec_t;

    vec_t tbl[5];
    bq_t  qd, ed;
    lq_t  ql, el;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int t = 0; t < 5; t++) begin
            tbl[t].rnd_ready = 1'b0;
            tbl[t].timing    = 1'b0;
            tbl[t].ovf_after = 1'b0;
        end
        tbl[0].n_in = 3;  tbl[0].n_out = 3;  tbl[0].timing = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tbl[0].din[j]  = 8'(j + 1);  tbl[0].lin[j]  = (j == 2);
            tbl[0].dout[j] = 8'(3 - j);  tbl[0].lout[j] = (j == 2);
        end
        tbl[1].n_in = 1;  tbl[1].n_out = 1;  tbl[1].timing = 1'b1;
        tbl[1].din[0] = 8'hA5; tbl[1].lin[0] = 1'b1; tbl[1].dout[0] = 8'hA5; tbl[1].lout[0] = 1'b1;
        tbl[2].n_in = 5;  tbl[2].n_out = 5;  tbl[2].rnd_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tbl[2].din[j]  = 8'(8'h10 + j);  tbl[2].lin[j]  = (j == 4);
            tbl[2].dout[j] = 8'(8'h14 - j);  tbl[2].lout[j] = (j == 4);
        end
        tbl[3].n_in = 20;
        for (int j = 0; j < 20; j++) begin
            tbl[3].din[j] = 8'(j);
            tbl[3].lin[j] = (j == 19);
        end
        for (int j = 0; j < 16; j++) begin
            tbl[3].dout[j] = 8'(15 - j);
            tbl[3].lout[j] = (j == 15);
        end
`ifdef LIFO_REV_DROP_EN
        tbl[3].n_out = 16;  tbl[3].ovf_after = 1'b1;
        tbl[4].ovf_after = 1'b1;
`else
        tbl[3].n_out = 20;
        for (int j = 0; j < 4; j++) begin
            tbl[3].dout[16+j] = 8'(19 - j);
            tbl[3].lout[16+j] = (j == 3);
        end
`endif
        tbl[4].n_in = 2;  tbl[4].n_out = 2;
        tbl[4].din[0]  = 8'hAA; tbl[4].lin[0]  = 1'b0; tbl[4].din[1]  = 8'hBB; tbl[4].lin[1]  = 1'b1;
        tbl[4].dout[0] = 8'hBB; tbl[4].lout[0] = 1'b0; tbl[4].dout[1] = 8'hAA; tbl[4].lout[1] = 1'b1;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_stk_re", 32'(stk_re), 32'd0);

        for (int t = 0; t < 5; t++) begin
            qd = {}; ql = {}; ed = {}; el = {};
            for (int j = 0; j < tbl[t].n_in; j++) begin
                qd.push_back(tbl[t].din[j]);
                ql.push_back(tbl[t].lin[j]);
            end
            for (int j = 0; j < tbl[t].n_out; j++) begin
                ed.push_back(tbl[t].dout[j]);
                el.push_back(tbl[t].lout[j]);
            end
            got_d = {}; got_l = {};
            rand_ready = tbl[t].rnd_ready;
            first_valid_cyc = -1;
            drive(qd, ql);
            wait_out(tbl[t].n_out, 2000);
            @(negedge clk);
            #2;
            compare(ed, el);
            chk("in_ready_after", 32'(in_ready), 32'd1);
            chk("ovf_after", 32'(ovf), 32'(tbl[t].ovf_after));
            if (tbl[t].timing) begin
                // out_valid rises two edges after the last accept edge; each byte then costs 3 cycles.
                chk("first_valid_latency", 32'(first_valid_cyc - last_acc_cyc), 32'd2);
                chk("fill_reopen", 32'(reopen_cyc - last_acc_cyc), 32'(3 * tbl[t].n_out));
            end
        end

        for (int r = 0; r < 4; r++) begin
            int nfr;
            int len;
            qd = {}; ql = {};
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                len = $urandom_range(1, 20);
                for (int j = 0; j < len; j++) begin
                    qd.push_back(8'($urandom));
                    ql.push_back(j == len - 1);
                end
            end
            model(qd, ql, ed, el);
            got_d = {}; got_l = {};
            rand_ready = 1'b1;
            drive(qd, ql);
            wait_out(ed.size(), 4000);
            @(negedge clk);
            compare(ed, el);
        end

        // Reset during drain discards the frame; the next frame reverses cleanly.
        rand_ready = 1'b0;
        got_d = {}; got_l = {};
        qd = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        ql = '{1'b0, 1'b0, 1'b0, 1'b1};
        drive(qd, ql);
        wait_out(1, 100);
        @(negedge clk);
        rst = 1'b1;
        ovf_model = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        got_d = {}; got_l = {};
        qd = '{8'h55, 8'h66};
        ql = '{1'b0, 1'b1};
        drive(qd, ql);
        wait_out(2, 200);
        @(negedge clk);
        ed = '{8'h66, 8'h55};
        el = '{1'b0, 1'b1};
        compare(ed, el);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
